// File: rtl/note_judge.sv
// Player-side judge for the 4-lane falling-note display: synchronises the lane buttons,
// grades presses against the two bottom rows, detects dropped notes and keeps score/combo/lives.
module note_judge #(
  parameter int PERFECT_PTS  = 3,
  parameter int GOOD_PTS     = 1,
  parameter int START_LIVES  = 5,
  parameter int FLASH_CYCLES = 25000000
) (
  input  logic        system_clk,
  input  logic        rst,
  input  logic        run,
  input  logic        shift_tick,
  input  logic [63:0] channel_in,
  input  logic [3:0]  btn,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic        judge_valid,
  output logic [1:0]  last_judge
);

  localparam int            FW           = $clog2(FLASH_CYCLES + 1);
  localparam logic [FW-1:0] FLASH_RELOAD = FW'(FLASH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    prev_q, prev_d;
  logic [3:0]    press_q, press_d;
  logic [2:0]    fill_q, fill_d;
  logic [3:0]    m14_q, m14_d;
  logic [3:0]    m15_q, m15_d;
  logic [15:0]   score_q, score_d;
  logic [7:0]    combo_q, combo_d;
  logic [7:0]    max_combo_q, max_combo_d;
  logic [2:0]    lives_q, lives_d;
  logic          game_over_q, game_over_d;
  logic          judge_valid_q, judge_valid_d;
  logic [1:0]    last_judge_q, last_judge_d;
  logic [FW-1:0] flash_q, flash_d;

  logic          playing;
  logic [3:0]    row14, row15;
  logic [3:0]    hit_press;
  logic [3:0]    perfect, good, bad, miss;
  logic [2:0]    n_perfect, n_good, n_bad, n_miss, n_hits;
  logic [31:0]   score_sum;
  logic [8:0]    combo_sum;
  logic          any_event;

  function automatic logic [2:0] count4(input logic [3:0] v);
    count4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // fill_q marks when prev_q holds a real synchronised sample, so a button
    // held through reset never looks like a fresh rising edge.
    fill_d  = {fill_q[1:0], 1'b1};
    press_d = sync2_q & ~prev_q & {4{fill_q[2]}};

    row14 = '0;
    row15 = '0;
    for (int k = 0; k < 4; k++) begin
      row14[k] = channel_in[16*k+14];
      row15[k] = channel_in[16*k+15];
    end

    playing   = (state_q == PLAY);
    hit_press = press_q & {4{playing}};
    perfect   = hit_press & row15 & ~m15_q;
    good      = hit_press & ~perfect & row14 & ~m14_q;
    bad       = hit_press & ~perfect & ~good;
    miss      = {4{shift_tick & playing}} & row15 & ~m15_q & ~perfect;

    n_perfect = count4(perfect);
    n_good    = count4(good);
    n_bad     = count4(bad);
    n_miss    = count4(miss);
    n_hits    = n_perfect + n_good;
    any_event = |{perfect, good, bad, miss};

    // Marks follow the notes down; they freeze together with judging outside PLAY.
    m14_d = m14_q;
    m15_d = m15_q;
    if (playing) begin
      if (shift_tick) begin
        m15_d = m14_q | good;
        m14_d = '0;
      end else begin
        m15_d = m15_q | perfect;
        m14_d = m14_q | good;
      end
    end

    score_sum = 32'(score_q) + 32'(PERFECT_PTS) * 32'(n_perfect) + 32'(GOOD_PTS) * 32'(n_good);
    score_d   = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];

    combo_sum = {1'b0, combo_q} + 9'(n_hits);
    if ((n_miss != 3'd0) || (n_bad != 3'd0)) begin
      combo_d = '0;
    end else if (combo_sum > 9'd255) begin
      combo_d = 8'd255;
    end else begin
      combo_d = combo_sum[7:0];
    end
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;

    lives_d = (n_miss >= lives_q) ? 3'd0 : lives_q - n_miss;

    judge_valid_d = any_event;
    last_judge_d  = last_judge_q;
    flash_d       = flash_q;
    if (any_event) begin
      if ((n_miss != 3'd0) || (n_bad != 3'd0)) begin
        last_judge_d = 2'b11;
      end else if (n_good != 3'd0) begin
        last_judge_d = 2'b10;
      end else begin
        last_judge_d = 2'b01;
      end
      flash_d = FLASH_RELOAD;
    end else if (flash_q != '0) begin
      flash_d = flash_q - FW'(1);
    end else begin
      last_judge_d = 2'b00;
    end

    state_d = state_q;
    case (state_q)
      IDLE: if (run) state_d = PLAY;
      PLAY: begin
        if (lives_d == 3'd0) begin
          state_d = OVER;
        end else if (!run) begin
          state_d = IDLE;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      press_q       <= '0;
      fill_q        <= '0;
      m14_q         <= '0;
      m15_q         <= '0;
      score_q       <= '0;
      combo_q       <= '0;
      max_combo_q   <= '0;
      lives_q       <= 3'(START_LIVES);
      game_over_q   <= 1'b0;
      judge_valid_q <= 1'b0;
      last_judge_q  <= 2'b00;
      flash_q       <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      press_q       <= press_d;
      fill_q        <= fill_d;
      m14_q         <= m14_d;
      m15_q         <= m15_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      max_combo_q   <= max_combo_d;
      lives_q       <= lives_d;
      game_over_q   <= game_over_d;
      judge_valid_q <= judge_valid_d;
      last_judge_q  <= last_judge_d;
      flash_q       <= flash_d;
    end
  end

  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_combo_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;
  assign judge_valid = judge_valid_q;
  assign last_judge  = last_judge_q;

endmodule
